// File: rtl/multi_enq_fifo_if.sv
// multi_enq_fifo_if -- handshake bundle for multi_enq_fifo.
//   Producer side: data_i/count_i/valid_i in, ready_o back.
//   Consumer side: valid_o/data_o/next_data_o out, yumi_i back.
//   master: the environment driving beats and consuming words.
//   slave : the FIFO itself.
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef N_WRITE
`define N_WRITE 4
`endif

interface multi_enq_fifo_if #(
  parameter int width_p   = `BIT_WIDTH,
  parameter int enqueue_n = `N_WRITE
);
  logic [enqueue_n-1:0][width_p-1:0]   data_i;
  logic [$clog2(enqueue_n+1)-1:0]      count_i;
  logic                                valid_i;
  logic                                ready_o;
  logic                                valid_o;
  logic [width_p-1:0]                  data_o;
  logic [width_p-1:0]                  next_data_o;
  logic                                yumi_i;

  modport master (
    output data_i, count_i, valid_i, yumi_i,
    input  ready_o, valid_o, data_o, next_data_o
  );

  modport slave (
    input  data_i, count_i, valid_i, yumi_i,
    output ready_o, valid_o, data_o, next_data_o
  );
endinterface

// File: rtl/multi_enq_fifo.sv
// multi_enq_fifo -- circular FIFO accepting up to enqueue_n words per beat,
// draining one word per cycle.
//   clk_i      : clock, rising edge
//   reset_n_i  : asynchronous active-low reset (pointers/occupancy only)
//   q (slave)  : data_i[enqueue_n], count_i, valid_i -> ready_o
//                valid_o, data_o (head), next_data_o (head+1) <- yumi_i
//   count_o    : registered occupancy, present only when
//                MULTI_ENQ_FIFO_COUNT_EN is defined
// Lane 0 of a beat is the oldest word; count_i lanes are taken from lane 0
// upward and clamped to enqueue_n.
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef DEGREE_N
`define DEGREE_N 8
`endif
`ifndef N_WRITE
`define N_WRITE 4
`endif

module multi_enq_fifo #(
  parameter int width_p   = `BIT_WIDTH,
  parameter int depth_p   = `DEGREE_N,
  parameter int enqueue_n = `N_WRITE
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
`ifdef MULTI_ENQ_FIFO_COUNT_EN
  output logic [$clog2(depth_p+1)-1:0]  count_o,
`endif
  multi_enq_fifo_if.slave               q
);
  localparam int AW = $clog2(depth_p);
  localparam int PW = AW + 1;            // MSB is the wrap bit
  localparam int OW = $clog2(depth_p+1);
  localparam int CW = $clog2(enqueue_n+1);

  logic [depth_p-1:0][width_p-1:0] mem;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] occ_r, occ_nxt;
  logic [CW-1:0] count_eff;
  logic          enq, deq;
  logic [enqueue_n-1:0][AW-1:0] lane_addr;
  logic [enqueue_n-1:0]         lane_we;
  logic [AW-1:0] rd_addr, rd_addr_nxt;

  // Flow control looks only at registered occupancy, so ready_o/valid_o
  // have no combinational path from the handshake inputs.
  assign q.ready_o = (occ_r <= OW'(depth_p - enqueue_n));
  assign q.valid_o = (occ_r != '0);

  assign count_eff = (q.count_i > CW'(enqueue_n)) ? CW'(enqueue_n) : q.count_i;
  assign enq       = q.valid_i & q.ready_o;
  assign deq       = q.yumi_i & q.valid_o;

  // Per-lane slot address; power-of-two depth makes the AW-bit add wrap.
  genvar l;
  for (l = 0; l < enqueue_n; l++) begin : g_lane
    assign lane_addr[l] = wr_ptr[AW-1:0] + AW'(l);
    assign lane_we[l]   = enq && (CW'(l) < count_eff);
  end

  always_comb begin
    occ_nxt = occ_r;
    if (enq) occ_nxt = occ_nxt + OW'(count_eff);
    if (deq) occ_nxt = occ_nxt - OW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_r  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(count_eff);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      occ_r <= occ_nxt;
    end
  end

  // Storage is not reset; valid_o/occupancy gate everything read out.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < enqueue_n; i++)
      if (lane_we[i]) mem[lane_addr[i]] <= q.data_i[i];
  end

  assign rd_addr     = rd_ptr[AW-1:0];
  assign rd_addr_nxt = rd_addr + AW'(1);

  assign q.data_o      = q.valid_o            ? mem[rd_addr]     : '0;
  assign q.next_data_o = (occ_r >= OW'(2))    ? mem[rd_addr_nxt] : '0;

`ifdef MULTI_ENQ_FIFO_COUNT_EN
  assign count_o = occ_r;
`else
  // occupancy stays internal in this build
`endif
endmodule

// File: doc/multi_enq_fifo.md
MULTI_ENQ_FIFO -- requirements
Module: multi_enq_fifo

Interface
REQ-001 SHALL have parameter width_p, default `BIT_WIDTH, bits per stored word.
REQ-002 SHALL have parameter depth_p, default `DEGREE_N, number of entries; power of two, at least enqueue_n.
REQ-003 SHALL have parameter enqueue_n, default `N_WRITE, maximum words accepted per input beat; at least 1.
REQ-004 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port data_i, input, enqueue_n x width_p, input beat; lane 0 is the oldest word.
REQ-007 SHALL have port count_i, input, $clog2(enqueue_n+1), number of valid lanes in the beat, taken from lane 0 upward.
REQ-008 SHALL have port valid_i, input, 1, input beat valid.
REQ-009 SHALL have port ready_o, output, 1, block can accept a full enqueue_n-word beat.
REQ-010 SHALL have port valid_o, output, 1, head word available.
REQ-011 SHALL have port data_o, output, width_p, head word.
REQ-012 SHALL have port next_data_o, output, width_p, word behind the head.
REQ-013 SHALL have port yumi_i, input, 1, consumer takes the head this cycle.

Function
REQ-014 SHALL store words in a circular buffer addressed by read and write pointers of $clog2(depth_p)+1 bits, with the MSB as the wrap bit.
REQ-015 SHALL enqueue when valid_i && ready_o: write data_i[0..count_i-1] to consecutive slots from wr_ptr in one cycle, wrapping modulo depth_p, and advance wr_ptr by count_i.
REQ-016 SHALL treat count_i==0 with valid_i as a no-op handshake, and SHALL clamp count_i>enqueue_n to enqueue_n.
REQ-017 SHALL drive ready_o = (depth_p - occupancy) >= enqueue_n, from registered state only, with no combinational path from valid_i, count_i or yumi_i.
REQ-018 SHALL drive valid_o = (occupancy != 0), registered-state only.
REQ-019 SHALL, on a dequeue (yumi_i && valid_o), advance rd_ptr by 1; yumi_i while valid_o==0 SHALL be ignored.
REQ-020 SHALL drive data_o = mem[rd_ptr] when valid_o, else 0.
REQ-021 SHALL drive next_data_o = mem[rd_ptr+1] when occupancy >= 2, else 0.
REQ-022 SHALL show a word enqueued at edge k on valid_o/data_o from cycle k+1 (1-cycle latency; no bypass).
REQ-023 SHALL allow enqueue and dequeue in the same cycle; occupancy_next = occupancy + count_eff - deq.
REQ-024 SHALL, in the full state (occupancy==depth_p), hold ready_o=0 and keep data intact; and in the empty state, hold valid_o=0, with the pointers equal including the wrap bit.
REQ-025 SHALL never overwrite unread data or emit unwritten data for any interleaving of handshakes.

Reset
REQ-026 SHALL, while reset_n_i==0, asynchronously clear rd_ptr, wr_ptr and occupancy to 0.
REQ-027 SHALL, during reset, drive valid_o=0, data_o=0 and next_data_o=0, and ready_o=1; memory contents need not be cleared.
REQ-028 SHALL, on reset asserted mid-operation, discard all queued words; no word enqueued before reset SHALL appear after it.

Configuration
REQ-029 SHALL, when macro MULTI_ENQ_FIFO_COUNT_EN is defined, add an output port count_o of width $clog2(depth_p+1) carrying the registered occupancy (0 in reset).
REQ-030 SHALL, when MULTI_ENQ_FIFO_COUNT_EN is undefined, omit count_o with all other behaviour identical.

Verification (width_p=16, depth_p=8, enqueue_n=4)
REQ-031 Reset, then one beat with count_i=4 and data 1,2,3,4 -> next cycle valid_o=1, data_o=1, next_data_o=2; ready_o=1 (occupancy 4).
REQ-032 Two beats of 4 with no yumi -> ready_o=0 at occupancy 8; a third beat is held off; yumi x8 -> output order is 1..8, then valid_o=0.
REQ-033 Partial beats with count_i=3 ×3 and yumi every cycle -> pointers wrap past 8; output order matches input order; count_o tracks occupancy when MULTI_ENQ_FIFO_COUNT_EN is defined.
REQ-034 At occupancy 4, enqueue count_i=4 and yumi_i=1 in the same cycle -> occupancy 7 next cycle, ready_o=0, head advanced by one.
REQ-035 yumi_i=1 while empty -> no pointer change, valid_o stays 0; valid_i with count_i=0 -> no state change.
REQ-036 reset_n_i pulsed low mid-cycle at occupancy 5 -> valid_o=0 and ready_o=1 immediately (asynchronous); no stale words appear after release.
